// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shifter: operation modes
// and FSM state values. Imported by shift_step and shift_seq.
package shift_pkg;

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate step.
// Ports: y (current value), mode (shift_pkg MODE_*), ny (stepped value),
// out (bit shifted out). Rotate is compiled only with SHIFT_ROTATE_EN;
// otherwise mode 11 is treated as a logical right shift.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] y,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] ny,
    output logic             out
);

    always_comb begin
        ny  = y;
        out = 1'b0;
        case (mode)
            MODE_LSL: begin
                ny  = {y[WIDTH-2:0], 1'b0};
                out = y[WIDTH-1];
            end
            MODE_ASR: begin
                ny  = {y[WIDTH-1], y[WIDTH-1:1]};
                out = y[0];
            end
`ifdef SHIFT_ROTATE_EN
            MODE_LSR: begin
                ny  = {1'b0, y[WIDTH-1:1]};
                out = y[0];
            end
            MODE_ROR: begin
                ny  = {y[0], y[WIDTH-1:1]};
                out = y[0];
            end
`else
            MODE_LSR, MODE_ROR: begin
                ny  = {1'b0, y[WIDTH-1:1]};
                out = y[0];
            end
`endif
            default: begin
                ny  = y;
                out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// Sequential shifter: one 1-bit step per clock until amt is used up.
// Ports: clk, rst (sync, active-high), start, mode, amt, a in;
// y, cout, busy, done out. Optional rotate via SHIFT_ROTATE_EN.
module shift_seq
    import shift_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [AW-1:0]    amt,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           state_n;
    logic [1:0]       mode_q;
    logic [AW-1:0]    count;
    logic [WIDTH-1:0] step_y;
    logic             step_out;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .y    (y),
        .mode (mode_q),
        .ny   (step_y),
        .out  (step_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = (amt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (count == AW'(1)) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Zero-amount requests clear cout at accept; otherwise cout is
    // written by every shift step.
    always_ff @(posedge clk) begin
        if (rst) begin
            y      <= '0;
            cout   <= 1'b0;
            count  <= '0;
            mode_q <= MODE_LSL;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        y      <= a;
                        mode_q <= mode;
                        count  <= amt;
                        if (amt == '0) begin
                            cout <= 1'b0;
                        end
                    end
                end
                ST_SHIFT: begin
                    y     <= step_y;
                    cout  <= step_out;
                    count <= count - AW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_shift_seq.sv
// Directed self-checking bench for shift_seq (WIDTH=8).
// Expected rotate results depend on SHIFT_ROTATE_EN.
module tb_shift_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic [2:0] amt;
    logic [7:0] a;
    logic [7:0] y;
    logic       cout;
    logic       busy;
    logic       done;

    int total;
    int passed;

    // observations from run_op
    int de;
    int dc;
    int bc;

    shift_seq #(
        .WIDTH (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .amt   (amt),
        .a     (a),
        .y     (y),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start an op, then watch 12 edges. Edge 1 is the start edge.
    // When poke matches an edge, a garbage start is driven right after it.
    task automatic run_op(
        input logic [7:0] ia,
        input logic [1:0] im,
        input logic [2:0] iamt,
        input int         poke
    );
        int edges;
        @(negedge clk);
        a     = ia;
        mode  = im;
        amt   = iamt;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 8'hA5;
        mode  = 2'b11;
        amt   = 3'd7;
        edges = 1;
        de    = -1;
        dc    = 0;
        bc    = 0;
        while (edges <= 12) begin
            if (busy) bc++;
            if (done) begin
                dc++;
                if (de < 0) de = edges;
            end
            if (poke == edges) begin
                start = 1'b1;
                a     = 8'hFF;
                mode  = 2'b01;
                amt   = 3'd1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            edges++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        mode  = 2'b00;
        amt   = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        total++; if (y !== 8'h00) $display("FAIL reset_y got %h want 00", y); else passed++;
        total++; if (cout !== 1'b0) $display("FAIL reset_cout got %b want 0", cout); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    endtask

    task automatic test_lsl();
        run_op(8'b10101010, 2'b00, 3'd1, 0);
        total++; if (y !== 8'b01010100) $display("FAIL lsl_y got %b want 01010100", y); else passed++;
        total++; if (cout !== 1'b1) $display("FAIL lsl_cout got %b want 1", cout); else passed++;
        total++; if (de != 2) $display("FAIL lsl_lat got %0d want 2", de); else passed++;
        total++; if (bc != 2) $display("FAIL lsl_busy got %0d want 2", bc); else passed++;
    endtask

    task automatic test_lsr();
        run_op(8'b00110011, 2'b01, 3'd3, 0);
        total++; if (y !== 8'b00000110) $display("FAIL lsr_y got %b want 00000110", y); else passed++;
        total++; if (cout !== 1'b0) $display("FAIL lsr_cout got %b want 0", cout); else passed++;
        total++; if (dc != 1) $display("FAIL lsr_ndone got %0d want 1", dc); else passed++;
        total++; if (de != 4) $display("FAIL lsr_lat got %0d want 4", de); else passed++;
    endtask

    task automatic test_asr();
        run_op(8'b10000001, 2'b10, 3'd7, 0);
        total++; if (y !== 8'b11111111) $display("FAIL asr_y got %b want 11111111", y); else passed++;
        total++; if (cout !== 1'b0) $display("FAIL asr_cout got %b want 0", cout); else passed++;
        total++; if (de != 8) $display("FAIL asr_lat got %0d want 8", de); else passed++;
    endtask

    task automatic test_ror();
        logic [7:0] ey;
`ifdef SHIFT_ROTATE_EN
        ey = 8'b11001100;
`else
        ey = 8'b00001100;
`endif
        run_op(8'b00110011, 2'b11, 3'd2, 0);
        total++; if (y !== ey) $display("FAIL ror_y got %b want %b", y, ey); else passed++;
        total++; if (cout !== 1'b1) $display("FAIL ror_cout got %b want 1", cout); else passed++;
        total++; if (de != 3) $display("FAIL ror_lat got %0d want 3", de); else passed++;
    endtask

    task automatic test_zero_amt();
        run_op(8'h5A, 2'b00, 3'd0, 0);
        total++; if (y !== 8'h5A) $display("FAIL zero_y got %h want 5a", y); else passed++;
        total++; if (cout !== 1'b0) $display("FAIL zero_cout got %b want 0", cout); else passed++;
        total++; if (de != 1) $display("FAIL zero_lat got %0d want 1", de); else passed++;
        total++; if (dc != 1) $display("FAIL zero_ndone got %0d want 1", dc); else passed++;
    endtask

    task automatic test_busy_start();
        run_op(8'h01, 2'b00, 3'd5, 2);
        total++; if (y !== 8'h20) $display("FAIL busy_y got %h want 20", y); else passed++;
        total++; if (cout !== 1'b0) $display("FAIL busy_cout got %b want 0", cout); else passed++;
        total++; if (de != 6) $display("FAIL busy_lat got %0d want 6", de); else passed++;
        total++; if (dc != 1) $display("FAIL busy_ndone got %0d want 1", dc); else passed++;
    endtask

    task automatic test_back_to_back();
        // start raised during the done cycle must be ignored
        run_op(8'h01, 2'b00, 3'd2, 3);
        total++; if (y !== 8'h04) $display("FAIL b2b_y got %h want 04", y); else passed++;
        total++; if (dc != 1) $display("FAIL b2b_ndone got %0d want 1", dc); else passed++;
        run_op(8'hC3, 2'b10, 3'd1, 0);
        total++; if (y !== 8'hE1) $display("FAIL b2b2_y got %h want e1", y); else passed++;
        total++; if (cout !== 1'b1) $display("FAIL b2b2_cout got %b want 1", cout); else passed++;
    endtask

    task automatic test_abort();
        int nd;
        @(negedge clk);
        a     = 8'hFF;
        mode  = 2'b00;
        amt   = 3'd6;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++; if (y !== 8'h00) $display("FAIL abort_y got %h want 00", y); else passed++;
        total++; if (cout !== 1'b0) $display("FAIL abort_cout got %b want 0", cout); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passed++;
        nd = 0;
        repeat (10) begin
            if (done) nd++;
            @(posedge clk);
            #1;
        end
        total++; if (nd != 0) $display("FAIL abort_done got %0d want 0", nd); else passed++;
        run_op(8'h80, 2'b01, 3'd4, 0);
        total++; if (y !== 8'h08) $display("FAIL post_y got %h want 08", y); else passed++;
        total++; if (de != 5) $display("FAIL post_lat got %0d want 5", de); else passed++;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        test_reset();
        test_lsl();
        test_lsr();
        test_asr();
        test_ror();
        test_zero_amt();
        test_busy_start();
        test_back_to_back();
        test_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
